// File: rtl/eth_tx_arb.sv
// Frame-atomic round-robin AXI-Stream mux feeding the MAC TX FIFO.
// Over-long frames are cut at MAX_BEATS, flagged on m_tuser and their tail drained.
module eth_tx_arb #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned MAX_BEATS = 96,
    parameter int unsigned CNT_W     = 32,
    localparam int unsigned KEEP_W   = DATA_W / 8,
    localparam int unsigned CH_W     = $clog2(NUM_CH),
    localparam int unsigned BCNT_W   = $clog2(MAX_BEATS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH*DATA_W-1:0]  s_tdata,
    input  logic [NUM_CH*KEEP_W-1:0]  s_tkeep,
    input  logic [NUM_CH-1:0]         s_tvalid,
    input  logic [NUM_CH-1:0]         s_tlast,
    output logic [NUM_CH-1:0]         s_tready,
    output logic [DATA_W-1:0]         m_tdata,
    output logic [KEEP_W-1:0]         m_tkeep,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    output logic                      m_tuser,
    input  logic                      m_tready,
    output logic [NUM_CH*CNT_W-1:0]   frame_cnt,
    output logic [NUM_CH*CNT_W-1:0]   trunc_cnt,
    output logic                      busy,
    output logic [CH_W-1:0]           cur_ch
);

    typedef enum logic [1:0] {StIdle, StPass, StDrop} state_e;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     g_q, g_d;
    logic [CH_W-1:0]     last_q, last_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
    logic [KEEP_W-1:0]   m_tkeep_q, m_tkeep_d;
    logic                m_tvalid_q, m_tvalid_d;
    logic                m_tlast_q, m_tlast_d;
    logic                m_tuser_q, m_tuser_d;
    logic [CNT_W-1:0]    frame_cnt_q [NUM_CH];
    logic [CNT_W-1:0]    frame_cnt_d [NUM_CH];
    logic [CNT_W-1:0]    trunc_cnt_q [NUM_CH];
    logic [CNT_W-1:0]    trunc_cnt_d [NUM_CH];

    logic [CH_W-1:0]     pick;
    logic                pick_vld;
    logic [CH_W-1:0]     idx;
    logic [DATA_W-1:0]   g_tdata;
    logic [KEEP_W-1:0]   g_tkeep;
    logic                g_tvalid;
    logic                g_tlast;
    logic                pass_rdy;
    logic                at_limit;

    // First requester after the last granted channel, wrapping modulo NUM_CH.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            idx = CH_W'((int'(last_q) + int'(i)) % int'(NUM_CH));
            if (!pick_vld && s_tvalid[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    assign g_tdata  = s_tdata[int'(g_q)*DATA_W +: DATA_W];
    assign g_tkeep  = s_tkeep[int'(g_q)*KEEP_W +: KEEP_W];
    assign g_tvalid = s_tvalid[g_q];
    assign g_tlast  = s_tlast[g_q];
    assign pass_rdy = !m_tvalid_q || m_tready;
    assign at_limit = (bcnt_q == BCNT_W'(MAX_BEATS - 1));

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        last_d      = last_q;
        bcnt_d      = bcnt_q;
        m_tdata_d   = m_tdata_q;
        m_tkeep_d   = m_tkeep_q;
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;
        m_tuser_d   = m_tuser_q;
        frame_cnt_d = frame_cnt_q;
        trunc_cnt_d = trunc_cnt_q;
        s_tready    = '0;

        if (m_tready) begin
            m_tvalid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    g_d     = pick;
                    last_d  = pick;
                    bcnt_d  = '0;
                    state_d = StPass;
                end
            end
            StPass: begin
                s_tready[g_q] = pass_rdy;
                if (pass_rdy && g_tvalid) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = g_tdata;
                    m_tkeep_d  = g_tkeep;
                    m_tlast_d  = g_tlast || at_limit;
                    m_tuser_d  = !g_tlast && at_limit;
                    if (g_tlast) begin
                        frame_cnt_d[g_q] = frame_cnt_q[g_q] + 1'b1;
                        state_d          = StIdle;
                    end else if (at_limit) begin
                        state_d = StDrop;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            StDrop: begin
                // Tail of a truncated frame is swallowed regardless of downstream.
                s_tready[g_q] = 1'b1;
                if (g_tvalid && g_tlast) begin
                    trunc_cnt_d[g_q] = trunc_cnt_q[g_q] + 1'b1;
                    state_d          = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            g_q        <= '0;
            last_q     <= CH_W'(NUM_CH - 1);
            bcnt_q     <= '0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                frame_cnt_q[i] <= '0;
                trunc_cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            last_q      <= last_d;
            bcnt_q      <= bcnt_d;
            m_tdata_q   <= m_tdata_d;
            m_tkeep_q   <= m_tkeep_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            m_tuser_q   <= m_tuser_d;
            frame_cnt_q <= frame_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt_out
        assign frame_cnt[i*CNT_W +: CNT_W] = frame_cnt_q[i];
        assign trunc_cnt[i*CNT_W +: CNT_W] = trunc_cnt_q[i];
    end

    assign m_tdata  = m_tdata_q;
    assign m_tkeep  = m_tkeep_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;
    assign m_tuser  = m_tuser_q;
    assign busy     = (state_q != StIdle);
    assign cur_ch   = g_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Scoreboard bench for eth_tx_arb: frame-level reference model predicts every output beat,
// grant order, ready behaviour and statistics counters.
module tb_eth_tx_arb;

    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 32;
    localparam int KEEP_W    = DATA_W / 8;
    localparam int MAX_BEATS = 4;
    localparam int CNT_W     = 2;
    localparam int CH_W      = $clog2(NUM_CH);

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH*DATA_W-1:0] s_tdata;
    logic [NUM_CH*KEEP_W-1:0] s_tkeep;
    logic [NUM_CH-1:0]        s_tvalid;
    logic [NUM_CH-1:0]        s_tlast;
    logic [NUM_CH-1:0]        s_tready;
    logic [DATA_W-1:0]        m_tdata;
    logic [KEEP_W-1:0]        m_tkeep;
    logic                     m_tvalid;
    logic                     m_tlast;
    logic                     m_tuser;
    logic                     m_tready;
    logic [NUM_CH*CNT_W-1:0]  frame_cnt;
    logic [NUM_CH*CNT_W-1:0]  trunc_cnt;
    logic                     busy;
    logic [CH_W-1:0]          cur_ch;

    eth_tx_arb #(
        .NUM_CH   (NUM_CH),
        .DATA_W   (DATA_W),
        .MAX_BEATS(MAX_BEATS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tuser  (m_tuser),
        .m_tready (m_tready),
        .frame_cnt(frame_cnt),
        .trunc_cnt(trunc_cnt),
        .busy     (busy),
        .cur_ch   (cur_ch)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [KEEP_W-1:0] k;
        logic              l;
        logic              u;
    } beat_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_vld_cyc = -1;
    int first_out_cyc = -1;
    int last_out_cyc  = -1;

    beat_t exp_q[$];
    int    grant_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + output monitor ----------------
    int               owner;
    int               mlast;
    int               beat;
    bit               fresh;
    logic [CNT_W-1:0] exp_fc [NUM_CH];
    logic [CNT_W-1:0] exp_tc [NUM_CH];
    logic [NUM_CH-1:0] exp_rdy;
    bit               prev_stall;
    logic [38:0]      prev_m;
    beat_t            e;
    logic             in_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            owner      = -1;
            mlast      = NUM_CH - 1;
            beat       = 0;
            fresh      = 1'b0;
            prev_stall = 1'b0;
            exp_q.delete();
            for (int c = 0; c < NUM_CH; c++) begin
                exp_fc[c] = '0;
                exp_tc[c] = '0;
            end
        end else begin
            // output side
            if (prev_stall) chk("stall_hold", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser}, prev_m);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("m_spurious_beat", 64'(m_tvalid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_tdata", 64'(m_tdata), 64'(e.d));
                    chk("m_tkeep", 64'(m_tkeep), 64'(e.k));
                    chk("m_tlast", 64'(m_tlast), 64'(e.l));
                    chk("m_tuser", 64'(m_tuser), 64'(e.u));
                end
            end
            if (m_tvalid && first_out_cyc < 0) first_out_cyc = cyc;
            if (m_tvalid && m_tready && m_tlast && last_out_cyc < 0) last_out_cyc = cyc;
            prev_stall = m_tvalid && !m_tready;
            prev_m     = {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser};

            for (int c = 0; c < NUM_CH; c++) begin
                chk("frame_cnt", 64'(frame_cnt[c*CNT_W +: CNT_W]), 64'(exp_fc[c]));
                chk("trunc_cnt", 64'(trunc_cnt[c*CNT_W +: CNT_W]), 64'(exp_tc[c]));
            end

            // input side
            if (owner < 0) begin
                chk("idle_s_tready", 64'(s_tready), 64'd0);
                chk("idle_busy", 64'(busy), 64'd0);
                for (int i = 1; i <= NUM_CH; i++) begin
                    if (owner < 0 && s_tvalid[(mlast + i) % NUM_CH]) owner = (mlast + i) % NUM_CH;
                end
                if (owner >= 0) begin
                    mlast = owner;
                    beat  = 0;
                    fresh = 1'b1;
                end
            end else begin
                if (fresh) grant_log.push_back(int'(cur_ch));
                fresh = 1'b0;
                chk("cur_ch", 64'(cur_ch), 64'(owner));
                chk("busy", 64'(busy), 64'd1);
                exp_rdy        = '0;
                exp_rdy[owner] = (beat >= MAX_BEATS) ? 1'b1 : (!m_tvalid || m_tready);
                chk("s_tready", 64'(s_tready), 64'(exp_rdy));
                if (s_tvalid[owner] && s_tready[owner]) begin
                    in_last = s_tlast[owner];
                    if (beat < MAX_BEATS) begin
                        exp_q.push_back('{d: s_tdata[owner*DATA_W +: DATA_W],
                                          k: s_tkeep[owner*KEEP_W +: KEEP_W],
                                          l: in_last || (beat == MAX_BEATS - 1),
                                          u: !in_last && (beat == MAX_BEATS - 1)});
                    end
                    if (in_last) begin
                        if (beat < MAX_BEATS) exp_fc[owner] = exp_fc[owner] + 1'b1;
                        else exp_tc[owner] = exp_tc[owner] + 1'b1;
                        owner = -1;
                    end
                    beat++;
                end
            end
        end
    end

    // ---------------- stimulus engine ----------------
    int frames_left [NUM_CH];
    int len_cfg     [NUM_CH];
    int flen        [NUM_CH];
    int fidx        [NUM_CH];
    int gap         [NUM_CH];
    bit in_frame    [NUM_CH];

    task automatic traffic(input int max_cycles, input bit rnd, input int stop_beats);
        logic [NUM_CH-1:0] acc;
        int n     = 0;
        int total = 0;
        bit active = 1'b1;
        bit stopped = 1'b0;
        while (active && !stopped && n < max_cycles) begin
            @(negedge clk);
            acc = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            n++;
            m_tready = rnd ? ($urandom_range(3) != 0) : 1'b1;
            active = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (acc[c]) begin
                    total++;
                    if (s_tlast[c]) begin
                        in_frame[c] = 1'b0;
                        gap[c]      = rnd ? int'($urandom_range(3)) : 0;
                    end else begin
                        fidx[c]++;
                    end
                end
                if (!s_tvalid[c] || acc[c]) begin
                    s_tvalid[c] = 1'b0;
                    s_tlast[c]  = 1'b0;
                    if (!in_frame[c] && frames_left[c] > 0) begin
                        if (gap[c] > 0) begin
                            gap[c]--;
                        end else begin
                            in_frame[c] = 1'b1;
                            fidx[c]     = 0;
                            flen[c]     = (len_cfg[c] != 0) ? len_cfg[c] : int'($urandom_range(7, 1));
                            frames_left[c]--;
                        end
                    end
                    if (in_frame[c] && !(rnd && $urandom_range(4) == 0)) begin
                        s_tvalid[c] = 1'b1;
                        s_tlast[c]  = (fidx[c] == flen[c] - 1);
                        s_tdata[c*DATA_W +: DATA_W] = DATA_W'($urandom);
                        s_tkeep[c*KEEP_W +: KEEP_W] = ($urandom_range(7) == 0) ? '0 : KEEP_W'($urandom);
                        if (first_vld_cyc < 0) first_vld_cyc = cyc;
                    end
                end
                if (in_frame[c] || frames_left[c] > 0) active = 1'b1;
            end
            if (stop_beats != 0 && total >= stop_beats) stopped = 1'b1;
        end
        if (active && !stopped) chk("traffic_timeout", 64'(n), 64'(max_cycles + 1));
    endtask

    task automatic drain();
        m_tready = 1'b1;
        for (int i = 0; i < 50 && (exp_q.size() != 0 || m_tvalid); i++) @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_idle", 64'(busy), 64'd0);
    endtask

    task automatic set_all(input int frames, input int len);
        for (int c = 0; c < NUM_CH; c++) begin
            frames_left[c] = frames;
            len_cfg[c]     = len;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            in_frame[c] = 1'b0;
            gap[c]      = 0;
            fidx[c]     = 0;
            flen[c]     = 0;
        end
        set_all(0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_m_tuser", 64'(m_tuser), 64'd0);
        chk("rst_m_tdata", 64'(m_tdata), 64'd0);
        chk("rst_m_tkeep", 64'(m_tkeep), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cur_ch", 64'(cur_ch), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_trunc_cnt", 64'(trunc_cnt), 64'd0);
        #1 rst_n = 1'b1;

        // single 4-beat frame on ch0: latency 2, full throughput
        first_vld_cyc = -1;
        first_out_cyc = -1;
        last_out_cyc  = -1;
        frames_left[0] = 1;
        len_cfg[0]     = 4;
        traffic(100, 1'b0, 0);
        drain();
        chk("first_beat_latency", 64'(first_out_cyc - first_vld_cyc), 64'd2);
        chk("frame_beats_back_to_back", 64'(last_out_cyc - first_out_cyc), 64'd3);

        // exact-limit frame, truncated frame, counter wrap
        frames_left[2] = 1; len_cfg[2] = 4;
        traffic(100, 1'b0, 0);
        frames_left[2] = 1; len_cfg[2] = 7;
        traffic(100, 1'b0, 0);
        frames_left[1] = 5; len_cfg[1] = 3;
        traffic(200, 1'b0, 0);
        drain();

        // round robin, all channels requesting continuously
        grant_log.delete();
        set_all(2, 2);
        traffic(200, 1'b0, 0);
        drain();
        chk("rr_grants", 64'(grant_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            chk("rr_order", 64'(grant_log[i]), 64'((2 + i) % NUM_CH));
        end

        // randomized traffic with bubbles, gaps and backpressure
        set_all(40, 0);
        traffic(20000, 1'b1, 0);
        drain();

        // reset while beat 3 of a 6-beat frame is presented
        set_all(0, 0);
        frames_left[3] = 1;
        len_cfg[3]     = 6;
        traffic(50, 1'b0, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_s_tready", 64'(s_tready), 64'd0);
        chk("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("midrst_trunc_cnt", 64'(trunc_cnt), 64'd0);
        s_tvalid = '0;
        s_tlast  = '0;
        set_all(0, 0);
        for (int c = 0; c < NUM_CH; c++) in_frame[c] = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        grant_log.delete();
        frames_left[0] = 1; len_cfg[0] = 2;
        frames_left[1] = 1; len_cfg[1] = 2;
        traffic(100, 1'b0, 0);
        drain();
        chk("post_rst_grants", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() >= 2) begin
            chk("post_rst_first", 64'(grant_log[0]), 64'd0);
            chk("post_rst_second", 64'(grant_log[1]), 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_arb.md
# eth_tx_arb

Frame-atomic, round-robin AXI-Stream multiplexer in front of the triple-speed Ethernet MAC TX FIFO. It merges NUM_CH independent 128-bit DPE transmit streams into the single `tx_fifo` stream. It enforces a maximum frame length by truncating and flagging over-long frames. It keeps per-channel good-frame and truncated-frame counters for CSR readout.

## Interface
Parameters:
- NUM_CH, 4, number of input channels (2..16)
- DATA_W, 128, tdata width; KEEP_W = DATA_W/8
- MAX_BEATS, 96, maximum beats per frame (1536 B at 16 B/beat)
- CNT_W, 32, width of each statistics counter

Ports:
- clk  in  1  sole clock, shared with the DPE/tx_fifo domain
- rst_n  in  1  asynchronous, active-low reset
- s_tdata  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- s_tkeep  in  NUM_CH*KEEP_W  per-channel byte enables
- s_tvalid  in  NUM_CH  per-channel valid
- s_tlast  in  NUM_CH  per-channel end of frame
- s_tready  out  NUM_CH  per-channel ready
- m_tdata  out  DATA_W  merged stream, registered
- m_tkeep  out  KEEP_W  registered
- m_tvalid  out  1  registered
- m_tlast  out  1  registered
- m_tuser  out  1  1 on the final beat of a truncated frame (MAC bad-frame marker)
- m_tready  in  1  downstream ready
- frame_cnt  out  NUM_CH*CNT_W  good frames forwarded per channel
- trunc_cnt  out  NUM_CH*CNT_W  truncated frames per channel
- busy  out  1  state != IDLE
- cur_ch  out  $clog2(NUM_CH)  currently granted channel

## Operation
- The FSM has three states: IDLE, PASS and DROP. A grant register `g`, a round-robin pointer `last` and a beat counter `bcnt` of width $clog2(MAX_BEATS+1) go with it.
- IDLE:
  - If any s_tvalid is set, grant the first set channel searching from last+1 modulo NUM_CH, then set g and last to it, clear bcnt and go to PASS.
  - All s_tready are 0 in IDLE.
- PASS:
  - s_tready[g] = !m_tvalid || m_tready. All other s_tready are 0.
  - An accepted beat loads the m_* register. m_tuser is 0.
  - If tlast is set on the accepted beat, increment frame_cnt[g] and go to IDLE.
  - Else, if bcnt == MAX_BEATS-1, force m_tlast=1 and m_tuser=1 on that beat and go to DROP.
  - Else increment bcnt.
- DROP:
  - s_tready[g] = 1, independent of m_tready.
  - Accepted beats are discarded and m_* is untouched.
  - When the tlast beat is accepted, increment trunc_cnt[g] and go to IDLE.
- When m_tvalid is 1 and m_tready is 0, m_tdata, m_tkeep, m_tlast and m_tuser hold stable. m_tvalid clears when the beat is consumed and no new beat is loaded.
- tkeep passes through unmodified; zero-keep beats are forwarded as-is.
- Counters wrap from 2^CNT_W-1 to 0.
- A frame whose tlast arrives exactly on beat MAX_BEATS is a good frame, not truncated.

## Timing
- Reset values:
  - m_tvalid, m_tlast, m_tuser, m_tdata, m_tkeep, s_tready, busy, cur_ch and all counters are 0.
  - The FSM is in IDLE.
  - last = NUM_CH-1, so channel 0 wins first.
- Latency:
  - A beat accepted in cycle t is on m_* in cycle t+1.
  - A first s_tvalid seen in IDLE at cycle t is accepted no earlier than t+1 and appears on m_* at t+2.
- Throughput is 1 beat/cycle within a frame while m_tready=1.
- There is exactly one idle cycle between frames. The tlast is accepted at t, the FSM is in IDLE at t+1 and the next first beat is accepted at t+2.
- Arbitration happens only in IDLE. A frame is never interleaved with another, and a channel going valid mid-frame waits.
- Simultaneous requests are resolved strictly by the round-robin order above. A single active channel is re-granted back-to-back, with the 1-cycle gap.
- Counter increments take effect on the clock edge of the accepting cycle.
- Reset asserted mid-frame: all state clears immediately. The partial frame is lost downstream with no tlast; the MAC frame FIFO discards it.

## Test plan
- Reset then single frame: ch0 sends 4 beats with tlast on beat 4 and m_tready=1 -> m shows 4 beats at cycles t+2..t+5, m_tlast only on beat 4, m_tuser=0, and frame_cnt[0]=1.
- Round-robin: all 4 channels hold 2-beat frames continuously -> grant order 0,1,2,3,0, one idle cycle between frames, and each frame_cnt=1 after 4 frames.
- Backpressure: m_tready toggles 1,0,0,1 during a 6-beat frame -> no beat lost or duplicated, m_* stable while stalled, and s_tready[g]=0 during stalls when m_tvalid=1.
- Truncation: MAX_BEATS=4, ch2 sends a 7-beat frame -> m shows 4 beats, beat 4 has m_tlast=1 and m_tuser=1, beats 5-7 are drained without m_tvalid, trunc_cnt[2]=1 and frame_cnt[2]=0. An exactly 4-beat frame gives frame_cnt[2]=1 and m_tuser=0.
- Counter wrap: CNT_W=2 and 5 good frames on ch1 -> frame_cnt[1]=1.
- Reset mid-frame: rst_n low on beat 3 of a 6-beat frame -> the same cycle gives m_tvalid=0, busy=0 and counters=0, and the next frame after release is granted to ch0 first.
